// File: rtl/segre_pipeline_ctrl.sv
// Pipeline hazard/flush controller: RAW stalls, taken-branch ID kill, memory-busy freeze.
// Optional performance counters are enabled by defining SEGRE_PIPELINE_STATS_EN.
module segre_pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        valid_id_i,
    input  logic [4:0]  src_a_id_i,
    input  logic [4:0]  src_b_id_i,
    input  logic        valid_ex_i,
    input  logic        rf_we_ex_i,
    input  logic [4:0]  rf_waddr_ex_i,
    input  logic        valid_mem_i,
    input  logic        rf_we_mem_i,
    input  logic [4:0]  rf_waddr_mem_i,
    input  logic        valid_wb_i,
    input  logic        rf_we_wb_i,
    input  logic [4:0]  rf_waddr_wb_i,
    input  logic        br_taken_i,
    input  logic        mem_busy_i,
    output logic        block_pc_o,
    output logic        block_id_o,
    output logic        block_ex_o,
    output logic        block_mem_o,
    output logic        inject_nops_o,
    output logic        inject_ex_nop_o
`ifdef SEGRE_PIPELINE_STATS_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StMemWait
    } state_e;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_raw;
    logic       w_br;

    function automatic logic hit(input logic [4:0] src, input logic v, input logic we,
                                 input logic [4:0] addr);
        return (src != 5'd0) && v && we && (addr == src);
    endfunction

    function automatic logic src_hazard(input logic [4:0] src);
        return hit(src, valid_ex_i, rf_we_ex_i, rf_waddr_ex_i)
            || hit(src, valid_mem_i, rf_we_mem_i, rf_waddr_mem_i)
            || hit(src, valid_wb_i, rf_we_wb_i, rf_waddr_wb_i);
    endfunction

    assign w_raw = valid_id_i && (src_hazard(src_a_id_i) || src_hazard(src_b_id_i));
    assign w_br  = br_taken_i && valid_ex_i;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        block_pc_o      = 1'b0;
        block_id_o      = 1'b0;
        block_ex_o      = 1'b0;
        block_mem_o     = 1'b0;
        inject_nops_o   = 1'b0;
        inject_ex_nop_o = 1'b0;

        if (mem_busy_i) begin
            // Freeze the whole pipe; the flush counter keeps its value for after the wait.
            block_pc_o  = 1'b1;
            block_id_o  = 1'b1;
            block_ex_o  = 1'b1;
            block_mem_o = 1'b1;
            w_state_nxt = StMemWait;
        end else if (w_br) begin
            inject_nops_o   = 1'b1;
            inject_ex_nop_o = 1'b1;
            w_cnt_nxt       = FlushLoad;
            w_state_nxt     = (FLUSH_CYCLES > 0) ? StFlush : StRun;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_raw) begin
                        block_pc_o      = 1'b1;
                        block_id_o      = 1'b1;
                        inject_ex_nop_o = 1'b1;
                    end
                end
                StFlush: begin
                    inject_nops_o = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = StRun;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                StMemWait: begin
                    w_state_nxt = (r_cnt != 3'd0) ? StFlush : StRun;
                end
                default: begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end

        // Under reset the ID and EX inputs are forced to bubbles.
        if (!rsn_i) begin
            block_pc_o      = 1'b0;
            block_id_o      = 1'b0;
            block_ex_o      = 1'b0;
            block_mem_o     = 1'b0;
            inject_nops_o   = 1'b1;
            inject_ex_nop_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state <= StRun;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef SEGRE_PIPELINE_STATS_EN
    logic        w_br_accept;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    assign w_br_accept = w_br && !mem_busy_i;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (block_pc_o) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_br_accept) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;
`endif

endmodule

// File: doc/segre_pipeline_ctrl.md
SEGRE_PIPELINE_CTRL -- requirements
Module: segre_pipeline_ctrl

Interface
REQ-001 The parameter set SHALL be: FLUSH_CYCLES, 1, extra ID-kill cycles after a taken branch (legal 0..7).
REQ-002 The ports SHALL be:
- clk_i  in  1  clock; one clock domain.
- rsn_i  in  1  reset; asynchronous, active-low.
- valid_id_i  in  1  ID holds a valid instruction.
- src_a_id_i / src_b_id_i  in  5 each  ID source register identifiers.
- valid_ex_i, rf_we_ex_i  in  1 each  EX valid, EX writes RF.
- rf_waddr_ex_i  in  5  EX destination.
- valid_mem_i, rf_we_mem_i  in  1 each  MEM valid, MEM writes RF.
- rf_waddr_mem_i  in  5  MEM destination.
- valid_wb_i, rf_we_wb_i  in  1 each  WB valid, WB writes RF.
- rf_waddr_wb_i  in  5  WB destination.
- br_taken_i  in  1  EX resolved a taken branch/jump.
- mem_busy_i  in  1  data memory not ready.
- block_pc_o, block_id_o, block_ex_o, block_mem_o  out  1 each  hold the stage register.
- inject_nops_o  out  1  load NOP into ID register.
- inject_ex_nop_o  out  1  send a bubble from ID into EX.
- stall_cycles_o, flush_count_o  out  32 each  performance counters (macro only, REQ-017).

Function
REQ-003 raw SHALL be valid_id_i AND, for src_a_id_i or src_b_id_i nonzero, equal to the rf_waddr of any stage (EX/MEM/WB) whose valid and rf_we are both 1; x0 SHALL never hazard.
REQ-004 The FSM SHALL have states RUN, FLUSH, MEM_WAIT plus a 3-bit flush counter, both registered; outputs SHALL be combinational from state and current inputs (zero latency).
REQ-005 Event priority SHALL be mem_busy_i > (br_taken_i AND valid_ex_i) > raw.
REQ-006 When mem_busy_i=1 in any state: all four block_* = 1, both inject_* = 0, next state MEM_WAIT, counter frozen.
REQ-007 In MEM_WAIT with mem_busy_i=0: no blocks; next state FLUSH if counter != 0, else RUN.
REQ-008 On a taken branch (no mem_busy): inject_nops_o = 1 and inject_ex_nop_o = 1 in that cycle; counter loads FLUSH_CYCLES; next state FLUSH if FLUSH_CYCLES > 0, else RUN.
REQ-009 In FLUSH (no mem_busy, no new branch): inject_nops_o = 1; counter decrements; transition to RUN in the cycle the counter reaches 0.
REQ-010 A taken branch seen while in FLUSH SHALL reload the counter to FLUSH_CYCLES.
REQ-011 On raw in RUN (no higher-priority event): block_pc_o = block_id_o = inject_ex_nop_o = 1; block_ex_o = block_mem_o = 0; the stall persists every cycle raw holds.
REQ-012 In RUN with no event, all outputs SHALL be 0.
REQ-013 raw SHALL be ignored in FLUSH, where the ID content is being killed.

Reset
REQ-014 While rsn_i = 0: state = RUN, counter = 0, all block_* = 0, inject_nops_o = 1, inject_ex_nop_o = 1.
REQ-015 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abort immediately to RUN with no residual flush.
REQ-016 Counters SHALL reset to 0.

Configuration
REQ-017 With SEGRE_PIPELINE_STATS_EN defined:
- stall_cycles_o increments each cycle block_pc_o = 1.
- flush_count_o increments once per accepted taken branch.
- Both counters wrap at 2^32.
REQ-018 Without SEGRE_PIPELINE_STATS_EN, neither counter nor its port SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-019 EX writes x5 (valid, we); ID reads src_a = 5 -> block_pc/block_id/inject_ex_nop = 1 for 3 cycles as the producer moves EX->MEM->WB, then 0.
REQ-020 ID reads x0 while EX writes x0 -> no stall.
REQ-021 br_taken_i = 1 with FLUSH_CYCLES = 1 -> cycle 0 both inject_* = 1; cycle 1 inject_nops_o = 1 only; cycle 2 RUN, all outputs 0.
REQ-022 mem_busy_i = 1 for 4 cycles coincident with br_taken_i -> 4 cycles all blocks = 1, no injects, then RUN, no flush.
REQ-023 mem_busy_i = 1 in FLUSH with counter = 2 -> MEM_WAIT; on release, 2 further FLUSH cycles.
REQ-024 With the macro, 3 RAW stalls plus 1 branch -> stall_cycles_o = 3, flush_count_o = 1; rsn_i pulse clears both.
